// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmit engine: start, 8 data bits LSB first, optional parity, 1-2 stop bits
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic          ODD_BIT   = (PARITY_ODD != 0);
    localparam logic          PAR_EN    = (PARITY_EN != 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]    r_state;
    logic [CW-1:0] r_baud_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic          r_tx;
    logic          r_done;

    logic          w_handshake;
    logic          w_bit_end;

    assign w_handshake = tx_valid && (r_state == S_IDLE);
    assign w_bit_end   = (r_baud_cnt == BAUD_LAST);

    assign tx_ready = (r_state == S_IDLE);
    assign tx_busy  = ~tx_ready;
    assign tx       = r_tx;
    assign tx_done  = r_done;

    // Frame sequencer: state, baud/bit counters, shift register, latched parity and done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'd0;
            r_parity   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_handshake) begin
                        r_shift    <= tx_data;
                        r_parity   <= (^tx_data) ^ ODD_BIT;
                        r_state    <= S_START;
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= 3'd0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state    <= S_DATA;
                        r_baud_cnt <= '0;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_ONE;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_shift    <= {1'b0, r_shift[7:1]};
                        if (r_bit_cnt == 3'd7) begin
                            r_bit_cnt <= 3'd0;
                            r_state   <= PAR_EN ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_ONE;
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state    <= S_STOP;
                        r_baud_cnt <= '0;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_ONE;
                    end
                end
                S_STOP: begin
                    // The bit counter is reused to count stop bits so two stop bits need no extra counter
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_bit_cnt == STOP_LAST) begin
                            r_bit_cnt <= 3'd0;
                            r_state   <= S_IDLE;
                            r_done    <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_ONE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_baud_cnt <= '0;
                    r_bit_cnt  <= 3'd0;
                end
            endcase
        end
    end

    // Line driver: registered from the current state, so the line trails the state by one clock and never glitches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx <= 1'b1;
        end else begin
            case (r_state)
                S_START:  r_tx <= 1'b0;
                S_DATA:   r_tx <= r_shift[0];
                S_PARITY: r_tx <= r_parity;
                default:  r_tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - self-checking bench for uart_tx_serializer across four parity/stop configurations
module tb_uart_tx_serializer;

    localparam int N = 4;

    logic            clk;
    logic            reset;
    logic [3:0]      v;
    logic [3:0][7:0] d;
    logic [3:0]      w_tx;
    logic [3:0]      w_rdy;
    logic [3:0]      w_busy;
    logic [3:0]      w_done;

    int n_assert = 0;
    int n_fail   = 0;

    // Instance 0: even parity, 1 stop; 1: odd parity, 1 stop; 2: no parity, 1 stop; 3: no parity, 2 stop
    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx_serializer #(
            .CLKS_PER_BIT (N),
            .PARITY_EN    ((g < 2) ? 1 : 0),
            .PARITY_ODD   ((g == 1) ? 1 : 0),
            .STOP_BITS    ((g == 3) ? 2 : 1)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .tx_data  (d[g]),
            .tx_valid (v[g]),
            .tx_ready (w_rdy[g]),
            .tx       (w_tx[g]),
            .tx_busy  (w_busy[g]),
            .tx_done  (w_done[g])
        );
    end

    always #5 clk = ~clk;

    function automatic bit pe_of(input int k);
        return k < 2;
    endfunction

    function automatic bit odd_of(input int k);
        return k == 1;
    endfunction

    function automatic int sb_of(input int k);
        return (k == 3) ? 2 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int k, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk($sformatf("idle_tx[%0d]", k), w_tx[k], 1'b1);
            chk($sformatf("idle_ready[%0d]", k), w_rdy[k], 1'b1);
            chk($sformatf("idle_busy[%0d]", k), w_busy[k], 1'b0);
            chk($sformatf("idle_done[%0d]", k), w_done[k], 1'b0);
        end
    endtask

    // Offers byte b in the current (idle or done) cycle and checks the whole frame on the line.
    // With hold set, tx_valid stays high carrying mid_data, so the next byte is taken in the done cycle.
    // Returns at the negedge of the done cycle.
    task automatic frame(input int k, input logic [7:0] b, input logic [7:0] mid_data, input bit hold);
        logic bits[$];
        int   len;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        if (pe_of(k)) bits.push_back((^b) ^ odd_of(k));
        for (int s = 0; s < sb_of(k); s++) bits.push_back(1'b1);
        len = bits.size() * N;

        d[k] = b;
        v[k] = 1'b1;
        chk($sformatf("accept_ready[%0d]", k), w_rdy[k], 1'b1);
        @(negedge clk);
        chk($sformatf("latency_tx_high[%0d]", k), w_tx[k], 1'b1);
        chk($sformatf("busy_after_accept[%0d]", k), w_rdy[k], 1'b0);
        if (hold) d[k] = mid_data;
        else      v[k] = 1'b0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            chk($sformatf("tx[%0d] byte %02h cyc %0d", k, b, i), w_tx[k], bits[i / N]);
            chk($sformatf("done[%0d] cyc %0d", k, i), w_done[k], (i == len - 1));
            chk($sformatf("ready[%0d] cyc %0d", k, i), w_rdy[k], (i == len - 1));
            chk($sformatf("busy[%0d] cyc %0d", k, i), w_busy[k], (i != len - 1));
        end
    endtask

    initial begin
        logic [7:0] b_cur;
        logic [7:0] b_next;
        bit         hold;

        clk   = 1'b0;
        reset = 1'b1;
        v     = '0;
        d     = '0;

        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset_tx[%0d]", k), w_tx[k], 1'b1);
            chk($sformatf("reset_ready[%0d]", k), w_rdy[k], 1'b1);
            chk($sformatf("reset_busy[%0d]", k), w_busy[k], 1'b0);
            chk($sformatf("reset_done[%0d]", k), w_done[k], 1'b0);
        end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) idle(k, (k == 0) ? 50 : 2);

        // Even parity 0xA5, odd parity 0x00, no parity with one and two stop bits
        frame(0, 8'hA5, 8'h00, 1'b0);
        idle(0, 3);
        frame(1, 8'h00, 8'h00, 1'b0);
        idle(1, 3);
        frame(2, 8'h00, 8'h00, 1'b0);
        idle(2, 3);
        frame(3, 8'h00, 8'h00, 1'b0);
        idle(3, 3);

        // Back-to-back with tx_valid held high
        frame(0, 8'h55, 8'h0F, 1'b1);
        frame(0, 8'h0F, 8'h0F, 1'b0);
        idle(0, 2);

        // tx_data moves to 0xFF mid-frame; 0x3C must go out intact, 0xFF only after the done cycle
        frame(0, 8'h3C, 8'hFF, 1'b1);
        frame(0, 8'hFF, 8'hFF, 1'b0);
        idle(0, 2);

        // Reset during data bit 3 of 0x81
        d[0] = 8'h81;
        v[0] = 1'b1;
        @(negedge clk);
        v[0] = 1'b0;
        repeat (4 * N + 2) @(negedge clk);
        chk("pre_reset_bit3_low", w_tx[0], 1'b0);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_tx", w_tx[0], 1'b1);
        chk("async_reset_ready", w_rdy[0], 1'b1);
        chk("async_reset_busy", w_busy[0], 1'b0);
        chk("async_reset_done", w_done[0], 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("in_reset_done", w_done[0], 1'b0);
            chk("in_reset_tx", w_tx[0], 1'b1);
        end
        reset = 1'b0;
        idle(0, 2);
        frame(0, 8'h7E, 8'h00, 1'b0);
        idle(0, 2);

        // Random bytes on every configuration, randomly back-to-back or separated by idle gaps
        for (int k = 0; k < 4; k++) begin
            b_next = 8'($urandom);
            for (int n = 0; n < 12; n++) begin
                b_cur  = b_next;
                b_next = 8'($urandom);
                hold   = (n != 11) && ($urandom_range(0, 1) == 1);
                frame(k, b_cur, b_next, hold);
                if (!hold) idle(k, $urandom_range(1, 3));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
